// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the tinyRISC core: sequences fetch, decode, execute, memory
// and writeback, latches the decode flags, drives commit strobes and tracks errors.
module multicycle_control_unit #(
  parameter int OPCODE_W = 5,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                stall_in,
  input  logic                flag_eq,
  input  logic                flag_gt,
  output logic [2:0]          state,
  output logic                isRet,
  output logic                isSt,
  output logic                isWb,
  output logic                isImmediate,
  output logic                isBeq,
  output logic                isBgt,
  output logic                isUBranch,
  output logic                isLd,
  output logic                isCall,
  output logic                fetch_req,
  output logic                ir_load,
  output logic                alu_en,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                pc_load,
  output logic [1:0]          pc_sel,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retire_count,
  output logic                illegal_op,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_ERROR     = 3'd7
  } state_t;

  localparam int WAIT_W = $clog2(TIMEOUT);

  state_t            cur;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        flags;      // {Ret,St,Wb,Imm,Beq,Bgt,UBranch,Ld,Call}
  logic [8:0]        dec_flags;
  logic              legal;
  logic              ready;
  logic              wait_expired;
  logic              branch_taken;

  assign state = cur;
  assign {isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUBranch, isLd, isCall} = flags;

  assign legal        = (opcode <= OPCODE_W'(7));
  assign ready        = (cur == S_FETCH) ? imem_ready : dmem_ready;
  assign wait_expired = !ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign branch_taken = (isBeq & flag_eq) | (isBgt & flag_gt);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_flags = 9'b0;
    case (opcode)
      OPCODE_W'(0): dec_flags = 9'b001000000;
      OPCODE_W'(1): dec_flags = 9'b001100000;
      OPCODE_W'(2): dec_flags = 9'b001000010;
      OPCODE_W'(3): dec_flags = 9'b010000000;
      OPCODE_W'(4): dec_flags = 9'b000010100;
      OPCODE_W'(5): dec_flags = 9'b000001100;
      OPCODE_W'(6): dec_flags = 9'b000000001;
      OPCODE_W'(7): dec_flags = 9'b100000000;
      default:      dec_flags = 9'b0;
    endcase
  end

  always_comb begin
    fetch_req  = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    pc_load    = 1'b0;
    pc_sel     = 2'd0;
    instr_done = 1'b0;
    case (cur)
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_load   = imem_ready;
      end
      S_EXECUTE: begin
        pc_sel = isRet ? 2'd2 : (branch_taken ? 2'd1 : 2'd0);
        if (!stall_in) begin
          alu_en = 1'b1;
          if (isBeq | isBgt | isRet) begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
          end
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = isSt;
        if (dmem_ready && isSt) begin
          pc_load    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WRITEBACK: begin
        wb_sel = isLd ? 2'd1 : (isCall ? 2'd2 : 2'd0);
        pc_sel = isCall ? 2'd1 : 2'd0;
        if (!stall_in) begin
          rf_we      = 1'b1;
          pc_load    = 1'b1;
          instr_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_FETCH;
      wait_cnt     <= '0;
      flags        <= '0;
      retire_count <= '0;
      illegal_op   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (instr_done) retire_count <= retire_count + CNT_W'(1);

      // The wait counter only runs in the two handshake states, so it is zero on entry to either.
      if ((cur == S_FETCH || cur == S_MEM) && !ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                            wait_cnt <= '0;

      case (cur)
        S_FETCH: begin
          if (imem_ready) cur <= S_DECODE;
          else if (wait_expired) begin
            cur         <= S_ERROR;
            timeout_err <= 1'b1;
          end
        end
        S_DECODE: begin
          if (!stall_in) begin
            flags <= dec_flags;
            if (legal) cur <= S_EXECUTE;
            else begin
              cur        <= S_ERROR;
              illegal_op <= 1'b1;
            end
          end
        end
        S_EXECUTE: begin
          if (!stall_in) begin
            if (isBeq | isBgt | isRet) cur <= S_FETCH;
            else if (isLd | isSt)      cur <= S_MEM;
            else                       cur <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          if (dmem_ready) cur <= isLd ? S_WRITEBACK : S_FETCH;
          else if (wait_expired) begin
            cur         <= S_ERROR;
            timeout_err <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (!stall_in) cur <= S_FETCH;
        end
        default: cur <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle vector table through a
// scoreboard queue, plus directed sequences for decode flags, errors and reset.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opcode;
  logic        imem_ready, dmem_ready, stall_in, flag_eq, flag_gt;
  logic [2:0]  state;
  logic        isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUBranch, isLd, isCall;
  logic        fetch_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_load, instr_done;
  logic [1:0]  wb_sel, pc_sel;
  logic [31:0] retire_count;
  logic        illegal_op, timeout_err;

  logic [8:0]  flags_obs;
  logic [6:0]  ctl_obs;
  assign flags_obs = {isRet, isSt, isWb, isImmediate, isBeq, isBgt, isUBranch, isLd, isCall};
  assign ctl_obs   = {fetch_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, pc_load};

  multicycle_control_unit #(.OPCODE_W(5), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .stall_in(stall_in), .flag_eq(flag_eq), .flag_gt(flag_gt), .state(state),
    .isRet(isRet), .isSt(isSt), .isWb(isWb), .isImmediate(isImmediate), .isBeq(isBeq),
    .isBgt(isBgt), .isUBranch(isUBranch), .isLd(isLd), .isCall(isCall),
    .fetch_req(fetch_req), .ir_load(ir_load), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_load(pc_load), .pc_sel(pc_sel),
    .instr_done(instr_done), .retire_count(retire_count), .illegal_op(illegal_op),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] op;
    logic       im, dm, st, eq, gt;
    logic [2:0] exp_state;
    logic [6:0] exp_ctl;   // {fetch_req,ir_load,alu_en,dmem_req,dmem_we,rf_we,pc_load}
    logic [1:0] exp_wb;
    logic [1:0] exp_pc;
    logic       exp_done;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [4:0] op, input logic im, dm, st, eq, gt,
                              input logic [2:0] s, input logic [6:0] ctl, input logic [1:0] wb,
                              input logic [1:0] pc, input logic done, input int cnt);
    vec_t v;
    v.rst = r; v.op = op; v.im = im; v.dm = dm; v.st = st; v.eq = eq; v.gt = gt;
    v.exp_state = s; v.exp_ctl = ctl; v.exp_wb = wb; v.exp_pc = pc;
    v.exp_done = done; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    stall_in = 1'b0; flag_eq = 1'b0; flag_gt = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [8:0] exp_flags(input int op);
    case (op)
      0: return 9'b001000000;
      1: return 9'b001100000;
      2: return 9'b001000010;
      3: return 9'b010000000;
      4: return 9'b000010100;
      5: return 9'b000001100;
      6: return 9'b000000001;
      default: return 9'b100000000;
    endcase
  endfunction

  initial begin
    vec_t e;
    // R-type
    vecs.push_back(mk(0,0,1,0,0,0,0, 0,7'b1100000,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1,7'b0000000,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 2,7'b0010000,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 4,7'b0000011,0,0,1,0));
    // LD, three wait cycles in MEM (stall ignored there)
    vecs.push_back(mk(0,2,1,0,0,0,0, 0,7'b1100000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,0,0,0, 1,7'b0000000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,0,0,0, 2,7'b0010000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,0,0,0, 3,7'b0001000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,1,0,0, 3,7'b0001000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,0,0,0, 3,7'b0001000,0,0,0,1));
    vecs.push_back(mk(0,2,0,1,0,0,0, 3,7'b0001000,0,0,0,1));
    vecs.push_back(mk(0,2,0,0,0,0,0, 4,7'b0000011,1,0,1,1));
    // ST with three stall cycles in EXECUTE
    vecs.push_back(mk(0,3,1,0,0,0,0, 0,7'b1100000,0,0,0,2));
    vecs.push_back(mk(0,3,0,0,0,0,0, 1,7'b0000000,0,0,0,2));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,3,0,0,1,0,0, 2,7'b0000000,0,0,0,2));
    vecs.push_back(mk(0,3,0,0,0,0,0, 2,7'b0010000,0,0,0,2));
    vecs.push_back(mk(0,3,0,1,0,0,0, 3,7'b0001101,0,0,1,2));
    // BEQ taken, BEQ not taken (gt set), BGT taken (eq clear)
    vecs.push_back(mk(0,4,1,0,0,0,0, 0,7'b1100000,0,0,0,3));
    vecs.push_back(mk(0,4,0,0,0,0,0, 1,7'b0000000,0,0,0,3));
    vecs.push_back(mk(0,4,0,0,0,1,0, 2,7'b0010001,0,1,1,3));
    vecs.push_back(mk(0,4,1,0,0,0,0, 0,7'b1100000,0,0,0,4));
    vecs.push_back(mk(0,4,0,0,0,0,0, 1,7'b0000000,0,0,0,4));
    vecs.push_back(mk(0,4,0,0,0,0,1, 2,7'b0010001,0,0,1,4));
    vecs.push_back(mk(0,5,1,0,0,0,0, 0,7'b1100000,0,0,0,5));
    vecs.push_back(mk(0,5,0,0,0,0,0, 1,7'b0000000,0,0,0,5));
    vecs.push_back(mk(0,5,0,0,0,0,1, 2,7'b0010001,0,1,1,5));
    // CALL, RET
    vecs.push_back(mk(0,6,1,0,0,0,0, 0,7'b1100000,0,0,0,6));
    vecs.push_back(mk(0,6,0,0,0,0,0, 1,7'b0000000,0,0,0,6));
    vecs.push_back(mk(0,6,0,0,0,0,0, 2,7'b0010000,0,0,0,6));
    vecs.push_back(mk(0,6,0,0,0,0,0, 4,7'b0000011,2,1,1,6));
    vecs.push_back(mk(0,7,1,0,0,0,0, 0,7'b1100000,0,0,0,7));
    vecs.push_back(mk(0,7,0,0,0,0,0, 1,7'b0000000,0,0,0,7));
    vecs.push_back(mk(0,7,0,0,0,0,0, 2,7'b0010001,0,2,1,7));
    // I-type: stall ignored in FETCH, honoured in DECODE and WRITEBACK
    vecs.push_back(mk(0,1,1,0,1,0,0, 0,7'b1100000,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,1,0,0, 1,7'b0000000,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1,7'b0000000,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,0,0,0, 2,7'b0010000,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,1,0,0, 4,7'b0000000,0,0,0,8));
    vecs.push_back(mk(0,1,0,0,0,0,0, 4,7'b0000011,0,0,1,8));
    // ST aborted by reset in MEM: nothing retires, no dmem_req afterwards
    vecs.push_back(mk(0,3,1,0,0,0,0, 0,7'b1100000,0,0,0,9));
    vecs.push_back(mk(0,3,0,0,0,0,0, 1,7'b0000000,0,0,0,9));
    vecs.push_back(mk(0,3,0,0,0,0,0, 2,7'b0010000,0,0,0,9));
    vecs.push_back(mk(1,3,0,0,0,0,0, 3,7'b0001100,0,0,0,9));
    vecs.push_back(mk(0,3,0,0,0,0,0, 0,7'b1000000,0,0,0,0));

    do_reset();
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_flags", 32'(flags_obs), 32'd0);
    check("reset_count", retire_count, 32'd0);
    check("reset_errs", {30'd0, illegal_op, timeout_err}, 32'd0);
    check("reset_sel", {28'd0, wb_sel, pc_sel}, 32'd0);

    foreach (vecs[i]) begin
      step();
      rst = vecs[i].rst; opcode = vecs[i].op; imem_ready = vecs[i].im; dmem_ready = vecs[i].dm;
      stall_in = vecs[i].st; flag_eq = vecs[i].eq; flag_gt = vecs[i].gt;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(e.exp_state));
      check($sformatf("vec%0d_ctl", i), 32'(ctl_obs), 32'(e.exp_ctl));
      check($sformatf("vec%0d_sel", i), {28'd0, wb_sel, pc_sel}, {28'd0, e.exp_wb, e.exp_pc});
      check($sformatf("vec%0d_done", i), 32'(instr_done), 32'(e.exp_done));
      check($sformatf("vec%0d_count", i), retire_count, 32'(e.exp_cnt));
      check($sformatf("vec%0d_errs", i), {30'd0, illegal_op, timeout_err}, 32'd0);
    end

    // Decode flags for every legal opcode, observed in EXECUTE
    for (int op = 0; op < 8; op++) begin
      do_reset();
      opcode = 5'(op); imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      step();
      @(negedge clk);
      check($sformatf("flags_op%0d", op), 32'(flags_obs), 32'(exp_flags(op)));
    end

    // Ready on the last allowed wait cycle wins, then an illegal opcode
    do_reset();
    repeat (15) step();
    imem_ready = 1'b1; opcode = 5'd9;
    @(negedge clk);
    check("late_ready_ir_load", 32'(ir_load), 32'd1);
    step();
    imem_ready = 1'b0;
    @(negedge clk);
    check("late_ready_state", 32'(state), 32'd1);
    check("late_ready_no_timeout", 32'(timeout_err), 32'd0);
    step();
    @(negedge clk);
    check("illegal_state", 32'(state), 32'd7);
    check("illegal_flag", 32'(illegal_op), 32'd1);
    check("illegal_flags_zero", 32'(flags_obs), 32'd0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check("error_quiet", {23'd0, ctl_obs, instr_done, 1'b0}, 32'd0);
    step();
    @(negedge clk);
    check("error_held", 32'(state), 32'd7);
    do_reset();
    @(negedge clk);
    check("illegal_cleared", {29'd0, state, illegal_op}, 32'd0);

    // Fetch timeout after 16 cycles of imem_ready low
    repeat (15) step();
    @(negedge clk);
    check("pre_timeout", {28'd0, state, timeout_err}, 32'd0);
    step();
    @(negedge clk);
    check("timeout_state", 32'(state), 32'd7);
    check("timeout_flag", 32'(timeout_err), 32'd1);
    check("timeout_no_fetch", 32'(fetch_req), 32'd0);
    do_reset();
    @(negedge clk);
    check("timeout_cleared", {28'd0, state, timeout_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
